// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the three-port RAM arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int STARVE_W   = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2,
    OWN_DBG  = 2'd3
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the arbiter; slave is the arbiter's view,
// master is the view of the requesters and the RAM macro together.
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);

  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;

  logic              ls_req_valid;
  logic              ls_req_we;
  logic [ADDR_W-1:0] ls_req_addr;
  logic [DATA_W-1:0] ls_req_wdata;
  logic              ls_req_ready;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_data;

  logic              dbg_req_valid;
  logic              dbg_req_we;
  logic [ADDR_W-1:0] dbg_req_addr;
  logic [DATA_W-1:0] dbg_req_wdata;
  logic              dbg_req_ready;
  logic              dbg_rsp_valid;
  logic [DATA_W-1:0] dbg_rsp_data;

  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata,
    output dbg_req_ready, dbg_rsp_valid, dbg_rsp_data,
    output ram_wr_en, ram_addr, ram_data_in,
    input  ram_data_out
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata,
    input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_data,
    input  ram_wr_en, ram_addr, ram_data_in,
    output ram_data_out
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational priority resolver: DBG first, then a starved IF, then LS, then IF.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_valid,
  input  logic   ls_valid,
  input  logic   dbg_valid,
  input  logic   starve_hit,
  output owner_e owner
);

  always_comb begin
    owner = OWN_NONE;
    if (dbg_valid)                    owner = OWN_DBG;
    else if (if_valid && starve_hit)  owner = OWN_IF;
    else if (ls_valid)                owner = OWN_LS;
    else if (if_valid)                owner = OWN_IF;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for IF/LS/DBG: combinational grant and RAM drive,
// one-cycle tagged read response, and an IF anti-starvation counter.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  owner_e              pick;
  owner_e              grant;
  owner_e              rsp_owner;
  logic                rsp_is_wr;
  logic [STARVE_W-1:0] starve_cnt;
  logic                starve_hit;
  logic [DATA_W-1:0]   rd_data;

  assign starve_hit = (starve_cnt == STARVE_W'(STARVE_MAX));

  mem_arb_pick u_pick (
    .if_valid   (bus.if_req_valid),
    .ls_valid   (bus.ls_req_valid),
    .dbg_valid  (bus.dbg_req_valid),
    .starve_hit (starve_hit),
    .owner      (pick)
  );

  // Request stage: nothing is granted while reset is asserted.
  assign grant = rst_n ? pick : OWN_NONE;

  assign bus.if_req_ready  = (grant == OWN_IF);
  assign bus.ls_req_ready  = (grant == OWN_LS);
  assign bus.dbg_req_ready = (grant == OWN_DBG);

  always_comb begin
    bus.ram_wr_en   = 1'b0;
    bus.ram_addr    = '0;
    bus.ram_data_in = '0;
    case (grant)
      OWN_IF: begin
        bus.ram_addr    = bus.if_req_addr;
      end
      OWN_LS: begin
        bus.ram_wr_en   = bus.ls_req_we;
        bus.ram_addr    = bus.ls_req_addr;
        bus.ram_data_in = bus.ls_req_wdata;
      end
      OWN_DBG: begin
        bus.ram_wr_en   = bus.dbg_req_we;
        bus.ram_addr    = bus.dbg_req_addr;
        bus.ram_data_in = bus.dbg_req_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_owner  <= OWN_NONE;
      rsp_is_wr  <= 1'b0;
      starve_cnt <= '0;
    end else begin
      rsp_owner <= grant;
      rsp_is_wr <= bus.ram_wr_en;
      // A DBG grant leaves the count untouched.
      if (grant == OWN_IF || !bus.if_req_valid)
        starve_cnt <= '0;
      else if (grant == OWN_LS && !starve_hit)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Response stage: RAM output is routed to the owner of last cycle's grant.
  assign rd_data = rsp_is_wr ? '0 : bus.ram_data_out;

  assign bus.if_rsp_valid  = (rsp_owner == OWN_IF);
  assign bus.ls_rsp_valid  = (rsp_owner == OWN_LS);
  assign bus.dbg_rsp_valid = (rsp_owner == OWN_DBG);

  assign bus.if_rsp_data  = (rsp_owner == OWN_IF)  ? rd_data : '0;
  assign bus.ls_rsp_data  = (rsp_owner == OWN_LS)  ? rd_data : '0;
  assign bus.dbg_rsp_data = (rsp_owner == OWN_DBG) ? rd_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM plus a priority/memory reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous RAM macro: registered read, output held on writes.
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (bus.ram_wr_en) ram[bus.ram_addr] = bus.ram_data_in;
    else               ram_q <= ram[bus.ram_addr];
  end
  assign bus.ram_data_out = ram_q;

  logic [DW-1:0] mem_m [1024];
  int n_tests = 0;
  int n_fail  = 0;

  // Pending request per port: 0 = IF, 1 = LS, 2 = DBG.
  logic          pv  [3];
  logic          pwe [3];
  logic [AW-1:0] pa  [3];
  logic [DW-1:0] pd  [3];

  task automatic drive_reqs();
    bus.if_req_valid  = pv[0];
    bus.if_req_addr   = pa[0];
    bus.ls_req_valid  = pv[1];
    bus.ls_req_we     = pwe[1];
    bus.ls_req_addr   = pa[1];
    bus.ls_req_wdata  = pd[1];
    bus.dbg_req_valid = pv[2];
    bus.dbg_req_we    = pwe[2];
    bus.dbg_req_addr  = pa[2];
    bus.dbg_req_wdata = pd[2];
  endtask

  task automatic clear_reqs();
    for (int p = 0; p < 3; p++) begin
      pv[p] = 1'b0; pwe[p] = 1'b0; pa[p] = '0; pd[p] = '0;
    end
    drive_reqs();
  endtask

  function automatic logic [2:0] rdy();
    return {bus.dbg_req_ready, bus.ls_req_ready, bus.if_req_ready};
  endfunction

  function automatic logic [2:0] rsp_v();
    return {bus.dbg_rsp_valid, bus.ls_rsp_valid, bus.if_rsp_valid};
  endfunction

  function automatic logic [DW-1:0] rsp_d(int p);
    case (p)
      0:       return bus.if_rsp_data;
      1:       return bus.ls_rsp_data;
      default: return bus.dbg_rsp_data;
    endcase
  endfunction

  task automatic test_reset();
    for (int p = 0; p < 3; p++) begin
      pv[p] = 1'b1; pwe[p] = (p != 0); pa[p] = AW'(p + 1); pd[p] = 32'hA5A5_0000 + p;
    end
    drive_reqs();
    @(negedge clk);
    n_tests++;
    if (rdy() !== 3'b000 || bus.ram_wr_en !== 1'b0 || bus.ram_addr !== '0 || bus.ram_data_in !== '0) begin
      n_fail++;
      $display("FAIL reset_req: rdy=%b wr=%b addr=%0d din=%h, required all 0", rdy(), bus.ram_wr_en, bus.ram_addr, bus.ram_data_in);
    end
    n_tests++;
    if (rsp_v() !== 3'b000 || rsp_d(0) !== '0 || rsp_d(1) !== '0 || rsp_d(2) !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: rsp_v=%b d0=%h d1=%h d2=%h, required all 0", rsp_v(), rsp_d(0), rsp_d(1), rsp_d(2));
    end
    clear_reqs();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_if_read_top();
    ram[1023] = 32'h766E2C96;
    mem_m[1023] = 32'h766E2C96;
    pv[0] = 1'b1; pa[0] = AW'(1023); drive_reqs();
    @(negedge clk);
    n_tests++;
    if (rdy() !== 3'b001 || bus.ram_addr !== AW'(1023) || bus.ram_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL if_grant: rdy=%b addr=%0d wr=%b, required 001 1023 0", rdy(), bus.ram_addr, bus.ram_wr_en);
    end
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
    n_tests++;
    if (rsp_v() !== 3'b001 || bus.if_rsp_data !== 32'h766E2C96) begin
      n_fail++;
      $display("FAIL if_rsp: rsp_v=%b data=%h, required 001 766e2c96", rsp_v(), bus.if_rsp_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (rsp_v() !== 3'b000) begin
      n_fail++;
      $display("FAIL if_rsp_once: rsp_v=%b, required 000", rsp_v());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    pv[1] = 1'b1; pwe[1] = 1'b1; pa[1] = AW'(5); pd[1] = 32'hDEADBEEF; drive_reqs();
    @(negedge clk);
    n_tests++;
    if (rdy() !== 3'b010 || bus.ram_wr_en !== 1'b1 || bus.ram_addr !== AW'(5) || bus.ram_data_in !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL ls_write: rdy=%b wr=%b addr=%0d din=%h, required 010 1 5 deadbeef", rdy(), bus.ram_wr_en, bus.ram_addr, bus.ram_data_in);
    end
    mem_m[5] = 32'hDEADBEEF;
    @(posedge clk); #1;
    pwe[1] = 1'b0; drive_reqs();
    @(negedge clk);
    n_tests++;
    if (bus.ls_rsp_valid !== 1'b1 || bus.ls_rsp_data !== '0) begin
      n_fail++;
      $display("FAIL ls_write_cpl: valid=%b data=%h, required 1 0", bus.ls_rsp_valid, bus.ls_rsp_data);
    end
    n_tests++;
    if (rdy() !== 3'b010 || bus.ram_wr_en !== 1'b0 || bus.ram_addr !== AW'(5)) begin
      n_fail++;
      $display("FAIL ls_read_grant: rdy=%b wr=%b addr=%0d, required 010 0 5", rdy(), bus.ram_wr_en, bus.ram_addr);
    end
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
    n_tests++;
    if (bus.ls_rsp_valid !== 1'b1 || bus.ls_rsp_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL ls_raw: valid=%b data=%h, required 1 deadbeef", bus.ls_rsp_valid, bus.ls_rsp_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_priority();
    pv[0] = 1'b1; pa[0] = AW'(22);
    pv[1] = 1'b1; pa[1] = AW'(21);
    pv[2] = 1'b1; pa[2] = AW'(20);
    drive_reqs();
    @(negedge clk);
    n_tests++;
    if (rdy() !== 3'b100) begin
      n_fail++;
      $display("FAIL prio_dbg: rdy=%b, required 100", rdy());
    end
    @(posedge clk); #1;
    pv[2] = 1'b0; drive_reqs();
    @(negedge clk);
    n_tests++;
    if (rdy() !== 3'b010 || rsp_v() !== 3'b100 || bus.dbg_rsp_data !== mem_m[20]) begin
      n_fail++;
      $display("FAIL prio_ls: rdy=%b rsp_v=%b dbg_data=%h, required 010 100 %h", rdy(), rsp_v(), bus.dbg_rsp_data, mem_m[20]);
    end
    @(posedge clk); #1;
    pv[1] = 1'b0; drive_reqs();
    @(negedge clk);
    n_tests++;
    if (rdy() !== 3'b001 || rsp_v() !== 3'b010 || bus.ls_rsp_data !== mem_m[21]) begin
      n_fail++;
      $display("FAIL prio_if: rdy=%b rsp_v=%b ls_data=%h, required 001 010 %h", rdy(), rsp_v(), bus.ls_rsp_data, mem_m[21]);
    end
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
    n_tests++;
    if (rsp_v() !== 3'b001 || bus.if_rsp_data !== mem_m[22]) begin
      n_fail++;
      $display("FAIL prio_if_rsp: rsp_v=%b data=%h, required 001 %h", rsp_v(), bus.if_rsp_data, mem_m[22]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_starvation();
    pv[1] = 1'b1; pa[1] = AW'(7);
    pv[0] = 1'b1; pa[0] = AW'(9);
    drive_reqs();
    for (int k = 1; k <= 7; k++) begin
      logic [2:0] exp_r;
      exp_r = (k == 5) ? 3'b001 : 3'b010;
      @(negedge clk);
      n_tests++;
      if (rdy() !== exp_r) begin
        n_fail++;
        $display("FAIL starve_cycle%0d: rdy=%b, required %b", k, rdy(), exp_r);
      end
      if (k == 5) pv[0] = 1'b0;
      @(posedge clk); #1;
      drive_reqs();
    end
    clear_reqs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    pv[1] = 1'b1; pa[1] = AW'(3); drive_reqs();
    @(negedge clk);
    n_tests++;
    if (rdy() !== 3'b010) begin
      n_fail++;
      $display("FAIL rstmid_grant: rdy=%b, required 010", rdy());
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.ls_rsp_valid !== 1'b0 || bus.ls_rsp_data !== '0 || rdy() !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_drop: valid=%b data=%h rdy=%b, required 0 0 000", bus.ls_rsp_valid, bus.ls_rsp_data, rdy());
    end
    @(negedge clk);
    clear_reqs();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if (rsp_v() !== 3'b000) begin
        n_fail++;
        $display("FAIL rstmid_after%0d: rsp_v=%b, required 000", k, rsp_v());
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_idle_readback();
    clear_reqs();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_tests++;
      if (rdy() !== 3'b000 || rsp_v() !== 3'b000 || bus.ram_wr_en !== 1'b0 || bus.ram_addr !== '0 || bus.ram_data_in !== '0) begin
        n_fail++;
        $display("FAIL idle%0d: rdy=%b rsp_v=%b wr=%b addr=%0d din=%h, required all 0", k, rdy(), rsp_v(), bus.ram_wr_en, bus.ram_addr, bus.ram_data_in);
      end
      @(posedge clk); #1;
    end
    for (int a = 0; a <= 30; a++) begin
      pv[2] = (a < 30); pwe[2] = 1'b0; pa[2] = AW'(a); drive_reqs();
      @(negedge clk);
      if (a > 0) begin
        n_tests++;
        if (bus.dbg_rsp_valid !== 1'b1 || bus.dbg_rsp_data !== mem_m[a-1]) begin
          n_fail++;
          $display("FAIL readback%0d: valid=%b data=%h, required 1 %h", a - 1, bus.dbg_rsp_valid, bus.dbg_rsp_data, mem_m[a-1]);
        end
      end
      @(posedge clk); #1;
    end
    clear_reqs();
    @(posedge clk); #1;
  endtask

  task automatic test_random(int n);
    int            exp_own;
    int            prev_own = -1;
    logic          prev_wr  = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int            wait_c   = 0;
    logic [2:0]    exp_r;
    logic [DW-1:0] exp_d;
    for (int c = 0; c < n; c++) begin
      for (int p = 0; p < 3; p++) begin
        if (!pv[p] && $urandom_range(0, 99) < 55) begin
          pv[p]  = 1'b1;
          pwe[p] = (p != 0) && ($urandom_range(0, 1) == 1);
          pa[p]  = ($urandom_range(0, 3) == 0) ? AW'(1023) : AW'($urandom_range(0, 15));
          pd[p]  = $urandom;
        end
      end
      drive_reqs();
      @(negedge clk);
      exp_r = (prev_own < 0) ? 3'b000 : 3'(1 << prev_own);
      n_tests++;
      if (rsp_v() !== exp_r) begin
        n_fail++;
        $display("FAIL rnd%0d_rsp_valid: rsp_v=%b, required %b", c, rsp_v(), exp_r);
      end
      for (int p = 0; p < 3; p++) begin
        exp_d = (prev_own == p && !prev_wr) ? prev_data : '0;
        n_tests++;
        if (rsp_d(p) !== exp_d) begin
          n_fail++;
          $display("FAIL rnd%0d_rsp_data%0d: data=%h, required %h", c, p, rsp_d(p), exp_d);
        end
      end
      if (pv[2])                        exp_own = 2;
      else if (pv[0] && wait_c == SMAX) exp_own = 0;
      else if (pv[1])                   exp_own = 1;
      else if (pv[0])                   exp_own = 0;
      else                              exp_own = -1;
      exp_r = (exp_own < 0) ? 3'b000 : 3'(1 << exp_own);
      n_tests++;
      if (rdy() !== exp_r) begin
        n_fail++;
        $display("FAIL rnd%0d_ready: rdy=%b, required %b", c, rdy(), exp_r);
      end
      if (exp_own >= 0) begin
        n_tests++;
        if (bus.ram_addr !== pa[exp_own] || bus.ram_wr_en !== pwe[exp_own] ||
            (pwe[exp_own] && bus.ram_data_in !== pd[exp_own])) begin
          n_fail++;
          $display("FAIL rnd%0d_ram: wr=%b addr=%0d din=%h, required %b %0d %h", c, bus.ram_wr_en, bus.ram_addr, bus.ram_data_in, pwe[exp_own], pa[exp_own], pd[exp_own]);
        end
        prev_wr = pwe[exp_own];
        if (pwe[exp_own]) mem_m[pa[exp_own]] = pd[exp_own];
        else              prev_data = mem_m[pa[exp_own]];
      end else begin
        n_tests++;
        if (bus.ram_wr_en !== 1'b0 || bus.ram_addr !== '0 || bus.ram_data_in !== '0) begin
          n_fail++;
          $display("FAIL rnd%0d_ram_idle: wr=%b addr=%0d din=%h, required 0 0 0", c, bus.ram_wr_en, bus.ram_addr, bus.ram_data_in);
        end
      end
      if (!pv[0] || exp_own == 0) wait_c = 0;
      else if (exp_own == 1)      wait_c = (wait_c + 1 > SMAX) ? SMAX : wait_c + 1;
      prev_own = exp_own;
      if (exp_own >= 0) pv[exp_own] = 1'b0;
      @(posedge clk); #1;
    end
    clear_reqs();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]   = $urandom;
      mem_m[i] = ram[i];
    end
    clear_reqs();
    test_reset();
    test_if_read_top();
    test_write_read();
    test_priority();
    test_starvation();
    test_reset_mid();
    test_idle_readback();
    test_random(400);
    test_idle_readback();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing the 1024×32 synchronous RAM among three requesters: instruction fetch (IF), load/store (LS), and a debug/loader port (DBG). Sits between the CORDIC processor core and the RAM macro. Grants at most one access per cycle. Returns read data one cycle after grant, tagged to the owning port. Fixed priority (DBG > LS > IF) plus an anti-starvation counter for IF.

## Interface
Parameters:
- ADDR_W, 10, RAM address width
- DATA_W, 32, RAM word width
- STARVE_MAX, 4, consecutive cycles IF may wait (IF valid, LS granted) before IF is forced ahead of LS; range 1..15

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req_valid  in  1  IF read request
- if_req_addr  in  ADDR_W  IF read address
- if_req_ready  out  1  IF request accepted this cycle
- if_rsp_valid  out  1  IF read data valid
- if_rsp_data  out  DATA_W  IF read data
- ls_req_valid  in  1  LS request
- ls_req_we  in  1  1 = write, 0 = read
- ls_req_addr  in  ADDR_W  LS address
- ls_req_wdata  in  DATA_W  LS write data
- ls_req_ready  out  1  LS request accepted
- ls_rsp_valid  out  1  LS completion (reads and writes)
- ls_rsp_data  out  DATA_W  LS read data; meaningful only for reads
- dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata, dbg_req_ready, dbg_rsp_valid, dbg_rsp_data: same as LS
- ram_wr_en  out  1  to RAM write enable
- ram_addr  out  ADDR_W  to RAM address
- ram_data_in  out  DATA_W  to RAM write data
- ram_data_out  in  DATA_W  from RAM registered read data

## Operation
- The grant is combinational in the request cycle. A request is accepted when valid && ready. At most one ready is high per cycle.
- Priority:
  - DBG always wins if valid.
  - Otherwise, if starve_cnt == STARVE_MAX and if_req_valid, IF wins.
  - Otherwise LS, then IF.
- The winning request drives ram_wr_en, ram_addr and ram_data_in combinationally. IF drives ram_wr_en=0.
- With no grant: ram_wr_en=0, ram_addr=0, ram_data_in=0.
- Owner register rsp_owner (NONE/IF/LS/DBG) loads the granted owner each cycle, or NONE when nothing is granted. Register rsp_is_wr records whether the granted access was a write.
- In the cycle after a grant, the <owner>_rsp_valid signal is 1 for exactly one cycle.
  - <owner>_rsp_data = ram_data_out for reads.
  - All rsp_data outputs are 0 when not valid or on write completion. The RAM does not update data_out on writes.
- starve_cnt (4 bits):
  - Cleared when IF is granted or if_req_valid=0.
  - Incremented when if_req_valid=1 and LS is granted, saturating at STARVE_MAX.
  - Held when DBG is granted.
- Requesters must hold valid and payload stable until ready. A response cannot be back-pressured.

## Timing
- Reset (rst_n low, asynchronous): rsp_owner=NONE, rsp_is_wr=0, starve_cnt=0.
- While rst_n is low, every output is 0, including all readies and ram_wr_en.
- Reset mid-access: any pending response is dropped. rsp_valid falls immediately.
- Latency: grant in cycle N, rsp_valid in cycle N+1.
- Throughput: one access per cycle. Back-to-back grants to the same or different ports are allowed, and responses follow in the same order.
- Simultaneous events: a write accepted in cycle N followed by a read of the same address in N+1 returns the new data in N+2.
- Boundaries:
  - Address 1023 and address 0 behave normally; there is no wrap.
  - Saturation: with STARVE_MAX=4 and LS continuously valid, IF is granted at the latest on the 5th cycle of waiting.

## Structure
- Package mem_arb_pkg holds:
  - ADDR_W and DATA_W defaults
  - owner_e enum {OWN_NONE, OWN_IF, OWN_LS, OWN_DBG}, 2 bits
  - STARVE_W = 4
- One sub-module, mem_arb_pick: a purely combinational priority resolver. Inputs are the three valids and starve_hit; output is owner_e.
- Top level holds the registers and the data muxing.
- Target size is roughly 150–250 lines of RTL.

## Test plan
- Reset release with RAM word 1023 = 32'h766E2C96: IF reads 1023 → if_req_ready in cycle N, if_rsp_valid=1 with data 32'h766E2C96 in N+1. All other rsp_valid stay 0.
- LS writes 32'hDEADBEEF to address 5 in cycle N, LS reads 5 in N+1 → ls_rsp_valid in N+1 with data 0, then data 32'hDEADBEEF in N+2.
- DBG, LS and IF all valid in the same cycle → only dbg_req_ready=1. The next cycle, with DBG dropped, LS is granted. IF is granted afterwards.
- LS continuously valid, IF valid, STARVE_MAX=4 → IF granted on the 5th waiting cycle, then starve_cnt returns to 0 and LS resumes.
- rst_n pulled low in the cycle after an LS read grant → ls_rsp_valid is 0 immediately and no response appears after rst_n rises.
- Idle cycles with no valid → ram_wr_en=0, ram_addr=0, all ready/rsp_valid 0. RAM contents are unchanged, checked by read-back of addresses 0..29.
